// File: rtl/vga_sync_gen.sv
// VGA timing generator: free-running pixel/line counters, sync decode,
// and a one-stage output register aligning colour with the sync pulses.
module vga_sync_gen #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       clk_vga,
  input  logic       rst,
  input  logic [7:0] rgb_in,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       frame_start,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic [7:0] rgb_out
);

  localparam logic [9:0] H_MAX  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_MAX  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VLIM = 10'(H_VIS);
  localparam logic [9:0] V_VLIM = 10'(V_VIS);
  localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_end;
  logic       v_end;
  logic       hs_n;
  logic       vs_n;

  assign h_end = (h_cnt == H_MAX);
  assign v_end = (v_cnt == V_MAX);

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_end) begin
      h_cnt <= '0;
      v_cnt <= v_end ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign pixel_x     = h_cnt;
  assign pixel_y     = v_cnt;
  assign video_on    = (h_cnt < H_VLIM) && (v_cnt < V_VLIM);
  assign frame_start = (h_cnt == '0) && (v_cnt == '0);
  assign hs_n        = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
  assign vs_n        = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));

  // Syncs pass through the same register stage as colour so they stay aligned.
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      vga_hs  <= 1'b1;
      vga_vs  <= 1'b1;
      rgb_out <= '0;
    end else begin
      vga_hs  <= hs_n;
      vga_vs  <= vs_n;
      rgb_out <= video_on ? rgb_in : 8'h00;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: a shrunk-timing instance for
// full-frame behaviour plus a default-timing instance for one line.
module tb_vga_sync_gen;

  localparam int HV = 16, HF = 2, HS = 4, HB = 3;
  localparam int VV = 8, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       clk_vga = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rgb_in = 8'h00;
  logic [9:0] pixel_x, pixel_y;
  logic       video_on, frame_start, vga_hs, vga_vs;
  logic [7:0] rgb_out;
  logic [9:0] d_pixel_x, d_pixel_y;
  logic       d_video_on, d_frame_start, d_vga_hs, d_vga_vs;
  logic [7:0] d_rgb_out;

  int checks = 0;
  int passed = 0;
  int t = 0;
  logic [7:0] last_rgb = 8'h00;

  vga_sync_gen #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk_vga(clk_vga), .rst(rst), .rgb_in(rgb_in),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .frame_start(frame_start),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .rgb_out(rgb_out)
  );

  vga_sync_gen dut_def (
    .clk_vga(clk_vga), .rst(rst), .rgb_in(rgb_in),
    .pixel_x(d_pixel_x), .pixel_y(d_pixel_y),
    .video_on(d_video_on), .frame_start(d_frame_start),
    .vga_hs(d_vga_hs), .vga_vs(d_vga_vs), .rgb_out(d_rgb_out)
  );

  always #5 clk_vga = ~clk_vga;

  // Reference model: position is just elapsed edges modulo the frame geometry.
  function automatic bit m_vis(int c);
    int h = c % HT;
    int v = (c / HT) % VT;
    return (h < HV) && (v < VV);
  endfunction

  function automatic bit m_hs_n(int c);
    int h = c % HT;
    return !((h >= HV + HF) && (h < HV + HF + HS));
  endfunction

  function automatic bit m_vs_n(int c);
    int v = (c / HT) % VT;
    return !((v >= VV + VF) && (v < VV + VF + VS));
  endfunction

  task automatic tick(input logic [7:0] nxt);
    last_rgb = rgb_in;
    @(posedge clk_vga);
    t++;
    @(negedge clk_vga);
    rgb_in = nxt;
  endtask

  task automatic do_reset();
    @(negedge clk_vga);
    rst = 1'b1;
    @(negedge clk_vga);
    rst = 1'b0;
    t = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rgb_in = 8'hFF;
    repeat (3) @(negedge clk_vga);
    checks++; if (pixel_x !== 10'd0) $display("FAIL rst_px got %0d want 0", pixel_x); else passed++;
    checks++; if (pixel_y !== 10'd0) $display("FAIL rst_py got %0d want 0", pixel_y); else passed++;
    checks++; if (video_on !== 1'b1) $display("FAIL rst_von got %b want 1", video_on); else passed++;
    checks++; if (frame_start !== 1'b1) $display("FAIL rst_fs got %b want 1", frame_start); else passed++;
    checks++; if (vga_hs !== 1'b1) $display("FAIL rst_hs got %b want 1", vga_hs); else passed++;
    checks++; if (vga_vs !== 1'b1) $display("FAIL rst_vs got %b want 1", vga_vs); else passed++;
    checks++; if (rgb_out !== 8'h00) $display("FAIL rst_rgb got %h want 00", rgb_out); else passed++;
    rst = 1'b0;
    t = 0;
    tick(8'h00);
    checks++; if (pixel_x !== 10'd1) $display("FAIL rel_px got %0d want 1", pixel_x); else passed++;
    checks++; if (frame_start !== 1'b0) $display("FAIL rel_fs got %b want 0", frame_start); else passed++;
    checks++; if (rgb_out !== 8'hFF) $display("FAIL rel_rgb got %h want ff", rgb_out); else passed++;
  endtask

  task automatic test_line_wrap();
    do_reset();
    repeat (HT - 1) tick(8'($urandom));
    checks++; if (pixel_x !== 10'(HT - 1) || pixel_y !== 10'd0)
      $display("FAIL line_end got %0d,%0d want %0d,0", pixel_x, pixel_y, HT - 1); else passed++;
    tick(8'($urandom));
    checks++; if (pixel_x !== 10'd0 || pixel_y !== 10'd1)
      $display("FAIL line_wrap got %0d,%0d want 0,1", pixel_x, pixel_y); else passed++;
    while (t < FT - 1) tick(8'($urandom));
    checks++; if (pixel_x !== 10'(HT - 1) || pixel_y !== 10'(VT - 1) || frame_start !== 1'b0)
      $display("FAIL frame_end got %0d,%0d fs=%b", pixel_x, pixel_y, frame_start); else passed++;
    tick(8'($urandom));
    checks++; if (pixel_x !== 10'd0 || pixel_y !== 10'd0 || frame_start !== 1'b1)
      $display("FAIL frame_wrap got %0d,%0d fs=%b want 0,0,1", pixel_x, pixel_y, frame_start); else passed++;
  endtask

  task automatic test_hsync();
    int low;
    int first;
    do_reset();
    for (int ln = 0; ln < 3; ln++) begin
      low = 0;
      first = -1;
      repeat (HT) begin
        tick(8'($urandom));
        checks++; if (vga_hs !== m_hs_n(t - 1))
          $display("FAIL hs_cyc t=%0d got %b want %b", t, vga_hs, m_hs_n(t - 1)); else passed++;
        if (vga_hs === 1'b0) begin
          low++;
          if (first < 0) first = (t - 1) % HT;
        end
      end
      checks++; if (low != HS) $display("FAIL hs_width line %0d got %0d want %0d", ln, low, HS); else passed++;
      checks++; if (first != HV + HF)
        $display("FAIL hs_start line %0d got %0d want %0d", ln, first, HV + HF); else passed++;
    end
  endtask

  task automatic test_vsync();
    int low = 0;
    int first = -1;
    do_reset();
    repeat (FT + HT) begin
      tick(8'($urandom));
      checks++; if (vga_vs !== m_vs_n(t - 1))
        $display("FAIL vs_cyc t=%0d got %b want %b", t, vga_vs, m_vs_n(t - 1)); else passed++;
      if (vga_vs === 1'b0 && t <= FT) begin
        low++;
        if (first < 0) first = t - 1;
      end
    end
    checks++; if (low != VS * HT) $display("FAIL vs_width got %0d want %0d", low, VS * HT); else passed++;
    checks++; if (first != (VV + VF) * HT)
      $display("FAIL vs_start got %0d want %0d", first, (VV + VF) * HT); else passed++;
  endtask

  task automatic test_frame();
    int vis = 0;
    int p1 = -1;
    int p2 = -1;
    do_reset();
    while (t < 2 * FT + 1) begin
      checks++; if (video_on !== m_vis(t) || frame_start !== (t % FT == 0))
        $display("FAIL decode t=%0d got von=%b fs=%b", t, video_on, frame_start); else passed++;
      if (t < FT && video_on === 1'b1) vis++;
      if (t > 0 && frame_start === 1'b1) begin
        if (p1 < 0) p1 = t; else if (p2 < 0) p2 = t;
      end
      tick(8'($urandom));
    end
    checks++; if (vis != HV * VV) $display("FAIL vis_count got %0d want %0d", vis, HV * VV); else passed++;
    checks++; if (p1 != FT) $display("FAIL fs_first got %0d want %0d", p1, FT); else passed++;
    checks++; if (p2 - p1 != FT) $display("FAIL fs_spacing got %0d want %0d", p2 - p1, FT); else passed++;
  endtask

  task automatic test_rgb();
    logic [7:0] exp;
    do_reset();
    rgb_in = 8'hA5;
    repeat (FT + 5) begin
      tick(8'hA5);
      exp = m_vis(t - 1) ? 8'hA5 : 8'h00;
      checks++; if (rgb_out !== exp)
        $display("FAIL rgb_const t=%0d got %h want %h", t, rgb_out, exp); else passed++;
    end
    repeat (FT) begin
      tick(8'($urandom));
      exp = m_vis(t - 1) ? last_rgb : 8'h00;
      checks++; if (rgb_out !== exp)
        $display("FAIL rgb_rand t=%0d got %h want %h", t, rgb_out, exp); else passed++;
    end
  endtask

  task automatic test_mid_reset();
    int h;
    int fs_at = -1;
    do_reset();
    h = int'($urandom_range(HV + HF + 1, HV + HF + HS - 1));
    repeat ((VV + VF) * HT + h) tick(8'($urandom));
    checks++; if (vga_hs !== 1'b0 || vga_vs !== 1'b0)
      $display("FAIL pre_rst got hs=%b vs=%b want 0,0", vga_hs, vga_vs); else passed++;
    #2 rst = 1'b1;
    #1;
    checks++; if (pixel_x !== 10'd0 || pixel_y !== 10'd0)
      $display("FAIL mid_rst_cnt got %0d,%0d want 0,0", pixel_x, pixel_y); else passed++;
    checks++; if (vga_hs !== 1'b1 || vga_vs !== 1'b1)
      $display("FAIL mid_rst_sync got hs=%b vs=%b want 1,1", vga_hs, vga_vs); else passed++;
    @(negedge clk_vga);
    rst = 1'b0;
    t = 0;
    while (t < FT + 2) begin
      tick(8'($urandom));
      checks++; if (vga_hs !== m_hs_n(t - 1) || vga_vs !== m_vs_n(t - 1))
        $display("FAIL post_rst_sync t=%0d got hs=%b vs=%b", t, vga_hs, vga_vs); else passed++;
      if (fs_at < 0 && frame_start === 1'b1) fs_at = t;
    end
    checks++; if (fs_at != FT) $display("FAIL post_rst_fs got %0d want %0d", fs_at, FT); else passed++;
  endtask

  task automatic test_default_line();
    int low = 0;
    int first = -1;
    do_reset();
    repeat (800) begin
      tick(8'($urandom));
      if (d_vga_hs === 1'b0) begin
        low++;
        if (first < 0) first = t - 1;
      end
      if (t == 799) begin
        checks++; if (d_pixel_x !== 10'd799 || d_pixel_y !== 10'd0)
          $display("FAIL def_end got %0d,%0d want 799,0", d_pixel_x, d_pixel_y); else passed++;
      end
    end
    checks++; if (d_pixel_x !== 10'd0 || d_pixel_y !== 10'd1)
      $display("FAIL def_wrap got %0d,%0d want 0,1", d_pixel_x, d_pixel_y); else passed++;
    checks++; if (low != 96) $display("FAIL def_hs_width got %0d want 96", low); else passed++;
    checks++; if (first != 656) $display("FAIL def_hs_start got %0d want 656", first); else passed++;
  endtask

  initial begin
    test_reset();
    test_line_wrap();
    test_hsync();
    test_vsync();
    test_frame();
    test_rgb();
    test_mid_reset();
    test_default_line();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
